// File: rtl/oc_gpio_irq.sv
// oc_gpio_irq: GPIO block with per-pin output/drive control, synchronised and
// debounced inputs, sticky edge status (write-1-to-clear) and one level irq.
module oc_gpio_irq #(
    parameter int          GpioCount     = 8,
    parameter int          SyncCycles    = 3,
    parameter int          DebounceWidth = 16,
    parameter int          AddrWidth     = 8,
    parameter logic [15:0] CsrId         = 16'h0007
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [AddrWidth-1:0] csrAddr,
    input  logic                 csrWrite,
    input  logic                 csrRead,
    input  logic [31:0]          csrWdata,
    output logic [31:0]          csrRdata,
    output logic                 csrReady,
    output logic [GpioCount-1:0] gpioOut,
    output logic [GpioCount-1:0] gpioTristate,
    input  logic [GpioCount-1:0] gpioIn,
    output logic                 irq
);

    localparam logic [DebounceWidth-1:0] CntZero = {DebounceWidth{1'b0}};
    localparam logic [DebounceWidth-1:0] CntMax  = {DebounceWidth{1'b1}};
    localparam logic [GpioCount-1:0]     PinZero = {GpioCount{1'b0}};
    localparam logic [GpioCount-1:0]     PinOnes = {GpioCount{1'b1}};

    // Packs one pin's register fields into their CSR bit positions.
    function automatic logic [31:0] pin_word(input logic o, input logic d, input logic in_b,
                                             input logic re, input logic fe,
                                             input logic rs, input logic fs);
        return {14'h0000, fs, rs, 2'b00, fe, re, 3'b000, in_b, 3'b000, d, 3'b000, o};
    endfunction

    logic [GpioCount-1:0]     sync_r [SyncCycles];
    logic [GpioCount-1:0]     sync_s;
    logic [GpioCount-1:0]     stable_r, stable_nxt_s;
    logic [DebounceWidth-1:0] cnt_r [GpioCount];
    logic [DebounceWidth-1:0] cnt_nxt_s [GpioCount];
    logic [DebounceWidth-1:0] thresh_r, thresh_m1_s;
    logic [GpioCount-1:0]     out_r, tri_r, rise_en_r, fall_en_r, rise_st_r, fall_st_r;
    logic [GpioCount-1:0]     rise_set_s, fall_set_s, rise_clr_s, fall_clr_s, pin_hit_s;
    logic [31:0]              rd_val_s, rdata_r;
    logic                     ready_r, irq_r;
    logic                     unused_s;

    assign sync_s       = sync_r[SyncCycles-1];
    assign csrRdata     = rdata_r;
    assign csrReady     = ready_r;
    assign gpioOut      = out_r;
    assign gpioTristate = tri_r;
    assign irq          = irq_r;
    assign unused_s     = ^csrWdata;

    // Multi-flop synchroniser for the asynchronous pad inputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int s = 0; s < SyncCycles; s++) sync_r[s] <= PinZero;
        end else begin
            sync_r[0] <= gpioIn;
            for (int s = 1; s < SyncCycles; s++) sync_r[s] <= sync_r[s-1];
        end
    end

    // Debounce: a threshold of 0 acts as 1; counter >= T-1 also covers a lowered threshold.
    always_comb begin
        thresh_m1_s  = (thresh_r == CntZero) ? CntZero : thresh_r - DebounceWidth'(1);
        stable_nxt_s = stable_r;
        for (int i = 0; i < GpioCount; i++) begin
            cnt_nxt_s[i] = CntZero;
            if (sync_s[i] != stable_r[i]) begin
                if (cnt_r[i] >= thresh_m1_s) begin
                    stable_nxt_s[i] = sync_s[i];
                    cnt_nxt_s[i]    = CntZero;
                end else if (cnt_r[i] != CntMax) begin
                    cnt_nxt_s[i] = cnt_r[i] + DebounceWidth'(1);
                end else begin
                    cnt_nxt_s[i] = cnt_r[i];
                end
            end else begin
                cnt_nxt_s[i] = CntZero;
            end
        end
        rise_set_s = stable_nxt_s & ~stable_r;
        fall_set_s = ~stable_nxt_s & stable_r;
    end

    // CSR address decode, read mux and write-1-to-clear strobes.
    always_comb begin
        rd_val_s  = 32'h0000_0000;
        pin_hit_s = PinZero;
        if (csrAddr == AddrWidth'(0)) begin
            rd_val_s = {CsrId, 8'h00, 8'(GpioCount)};
        end else if (csrAddr == AddrWidth'(1)) begin
            rd_val_s = 32'(thresh_r);
        end else begin
            for (int i = 0; i < GpioCount; i++) begin
                if (csrAddr == AddrWidth'(i + 2)) begin
                    pin_hit_s[i] = 1'b1;
                    rd_val_s = pin_word(out_r[i], ~tri_r[i], stable_r[i], rise_en_r[i],
                                        fall_en_r[i], rise_st_r[i], fall_st_r[i]);
                end else begin
                    pin_hit_s[i] = 1'b0;
                end
            end
        end
        rise_clr_s = (csrWrite && csrWdata[16]) ? pin_hit_s : PinZero;
        fall_clr_s = (csrWrite && csrWdata[17]) ? pin_hit_s : PinZero;
    end

    // Debounce state, edge status (set beats clear) and the registered interrupt.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stable_r  <= PinZero;
            rise_st_r <= PinZero;
            fall_st_r <= PinZero;
            irq_r     <= 1'b0;
            for (int i = 0; i < GpioCount; i++) cnt_r[i] <= CntZero;
        end else begin
            stable_r  <= stable_nxt_s;
            rise_st_r <= (rise_st_r & ~rise_clr_s) | rise_set_s;
            fall_st_r <= (fall_st_r & ~fall_clr_s) | fall_set_s;
            irq_r     <= |((rise_st_r & rise_en_r) | (fall_st_r & fall_en_r));
            for (int i = 0; i < GpioCount; i++) cnt_r[i] <= cnt_nxt_s[i];
        end
    end

    // Control registers written from the CSR bus; drive is stored inverted as tristate.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            thresh_r  <= CntZero;
            out_r     <= PinZero;
            tri_r     <= PinOnes;
            rise_en_r <= PinZero;
            fall_en_r <= PinZero;
        end else if (csrWrite) begin
            if (csrAddr == AddrWidth'(1)) begin
                thresh_r <= csrWdata[DebounceWidth-1:0];
            end else begin
                thresh_r <= thresh_r;
            end
            for (int i = 0; i < GpioCount; i++) begin
                if (pin_hit_s[i]) begin
                    out_r[i]     <= csrWdata[0];
                    tri_r[i]     <= ~csrWdata[4];
                    rise_en_r[i] <= csrWdata[12];
                    fall_en_r[i] <= csrWdata[13];
                end
            end
        end
    end

    // One-cycle response; data only for pure reads, zero otherwise.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ready_r <= 1'b0;
            rdata_r <= 32'h0000_0000;
        end else begin
            ready_r <= csrRead | csrWrite;
            rdata_r <= (csrRead && !csrWrite) ? rd_val_s : 32'h0000_0000;
        end
    end

endmodule

// File: tb/tb_oc_gpio_irq.sv
// Directed bench for oc_gpio_irq with an expected-read-data queue.
module tb_oc_gpio_irq;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  csrAddr = 8'h00;
    logic        csrWrite = 1'b0;
    logic        csrRead = 1'b0;
    logic [31:0] csrWdata = 32'h0;
    logic [31:0] csrRdata;
    logic        csrReady;
    logic [7:0]  gpioOut;
    logic [7:0]  gpioTristate;
    logic [7:0]  gpioIn = 8'h00;
    logic        irq;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] exp_q[$];

    oc_gpio_irq dut (
        .clock(clock), .reset(reset), .csrAddr(csrAddr), .csrWrite(csrWrite),
        .csrRead(csrRead), .csrWdata(csrWdata), .csrRdata(csrRdata), .csrReady(csrReady),
        .gpioOut(gpioOut), .gpioTristate(gpioTristate), .gpioIn(gpioIn), .irq(irq)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one request at a negedge; compare the response at the following negedge.
    task automatic csr_req(input string tag, input logic rd, input logic wr,
                           input logic [7:0] a, input logic [31:0] wd, input logic [31:0] exp);
        logic [31:0] e;
        @(negedge clock);
        csrRead = rd; csrWrite = wr; csrAddr = a; csrWdata = wd;
        exp_q.push_back(exp);
        @(negedge clock);
        csrRead = 1'b0; csrWrite = 1'b0;
        chk({tag, "_ready"}, {31'h0, csrReady}, 32'h1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk({tag, "_rdata"}, csrRdata, e);
        end else begin
            chk({tag, "_queue"}, 32'h0, 32'h1);
        end
    endtask

    initial begin
        // Reset values while held in reset
        #12;
        chk("rst_tri", {24'h0, gpioTristate}, 32'hFF);
        chk("rst_out", {24'h0, gpioOut}, 32'h0);
        chk("rst_irq", {31'h0, irq}, 32'h0);
        chk("rst_ready", {31'h0, csrReady}, 32'h0);
        @(negedge clock); reset = 1'b1;
        csr_req("id", 1'b1, 1'b0, 8'd0, 32'h0, 32'h0007_0008);

        // Output drive on pin 1
        csr_req("wr_p1", 1'b0, 1'b1, 8'd3, 32'h11, 32'h0);
        chk("drv_out", {24'h0, gpioOut}, 32'h02);
        chk("drv_tri", {24'h0, gpioTristate}, 32'hFD);
        @(negedge clock);
        chk("ready_pulse", {31'h0, csrReady}, 32'h0);
        chk("rdata_idle", csrRdata, 32'h0);
        csr_req("rd_p1", 1'b1, 1'b0, 8'd3, 32'h0, 32'h11);

        // Debounce threshold 5: 4-cycle glitch rejected, 5-cycle pulse accepted
        csr_req("wr_deb", 1'b0, 1'b1, 8'd1, 32'hFFFF_0005, 32'h0);
        csr_req("rd_deb", 1'b1, 1'b0, 8'd1, 32'h0, 32'h5);
        @(negedge clock); gpioIn[0] = 1'b1;
        repeat (4) @(negedge clock);
        gpioIn[0] = 1'b0;
        repeat (12) @(negedge clock);
        csr_req("glitch", 1'b1, 1'b0, 8'd2, 32'h0, 32'h0);
        @(negedge clock); gpioIn[0] = 1'b1;
        repeat (5) @(negedge clock);
        gpioIn[0] = 1'b0;
        repeat (14) @(negedge clock);
        csr_req("pulse5", 1'b1, 1'b0, 8'd2, 32'h0, 32'h0003_0000);
        csr_req("w1c_p0", 1'b0, 1'b1, 8'd2, 32'h0003_0000, 32'h0);
        csr_req("clr_p0", 1'b1, 1'b0, 8'd2, 32'h0, 32'h0);
        @(negedge clock); gpioIn[0] = 1'b1;
        repeat (20) @(negedge clock);
        csr_req("hold_p0", 1'b1, 1'b0, 8'd2, 32'h0, 32'h0001_0100);

        // Threshold 0 acts as 1: step reaches status at +4 cycles, irq at +5
        csr_req("deb0", 1'b0, 1'b1, 8'd1, 32'h0, 32'h0);
        csr_req("en_p2", 1'b0, 1'b1, 8'd4, 32'h1000, 32'h0);
        @(negedge clock); gpioIn[2] = 1'b1;
        repeat (4) @(negedge clock);
        chk("irq_early", {31'h0, irq}, 32'h0);
        @(negedge clock);
        chk("irq_set", {31'h0, irq}, 32'h1);
        csr_req("w1c_p2", 1'b0, 1'b1, 8'd4, 32'h0001_1000, 32'h0);
        chk("irq_hold", {31'h0, irq}, 32'h1);
        @(negedge clock);
        chk("irq_clr", {31'h0, irq}, 32'h0);
        csr_req("rd_p2", 1'b1, 1'b0, 8'd4, 32'h0, 32'h0000_1100);

        // Rising edge on the same cycle as its W1C: set wins
        @(negedge clock); gpioIn[2] = 1'b0;
        repeat (10) @(negedge clock);
        @(negedge clock); gpioIn[2] = 1'b1;
        repeat (2) @(negedge clock);
        csr_req("w1c_race", 1'b0, 1'b1, 8'd4, 32'h0003_1000, 32'h0);
        csr_req("race_st", 1'b1, 1'b0, 8'd4, 32'h0, 32'h0001_1100);
        chk("race_irq", {31'h0, irq}, 32'h1);

        // Boundaries: out-of-range address, simultaneous read and write
        csr_req("oor_rd", 1'b1, 1'b0, 8'd10, 32'h0, 32'h0);
        csr_req("oor_wr", 1'b0, 1'b1, 8'd10, 32'hFFFF_FFFF, 32'h0);
        csr_req("rdwr", 1'b1, 1'b1, 8'd3, 32'h01, 32'h0);
        chk("rdwr_tri", {24'h0, gpioTristate}, 32'hFF);
        chk("rdwr_out", {24'h0, gpioOut}, 32'h02);
        csr_req("rdwr_rb", 1'b1, 1'b0, 8'd3, 32'h0, 32'h01);

        // Asynchronous reset in the middle of a request
        @(negedge clock);
        csrRead = 1'b1; csrAddr = 8'd0;
        @(posedge clock);
        #2 reset = 1'b0;
        #1;
        chk("mid_ready", {31'h0, csrReady}, 32'h0);
        chk("mid_tri", {24'h0, gpioTristate}, 32'hFF);
        chk("mid_out", {24'h0, gpioOut}, 32'h0);
        chk("mid_irq", {31'h0, irq}, 32'h0);
        csrRead = 1'b0;
        gpioIn = 8'h00;
        @(negedge clock); reset = 1'b1;
        csr_req("post_p2", 1'b1, 1'b0, 8'd4, 32'h0, 32'h0);
        csr_req("post_deb", 1'b1, 1'b0, 8'd1, 32'h0, 32'h0);
        csr_req("post_id", 1'b1, 1'b0, 8'd0, 32'h0, 32'h0007_0008);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
